axil_sdram_req_arb: RTL

AXIL_SDRAM_REQ_ARB -- requirements
Module: axil_sdram_req_arb

---
 rtl/axil_sdram_req_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/axil_sdram_req_arb.sv
// Round-robin arbiter that moves AXI-Lite write/read FIFO entries onto a single-port SDRAM request bus.
// The optional read-wait timeout is compiled in by defining AXIL_SDRAM_RD_TIMEOUT_EN.
module axil_sdram_req_arb #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SDRAM_ADDR_WIDTH = 24,
    parameter int RD_TIMEOUT       = 255
) (
    input  logic                        s_axil_clk,
    input  logic                        s_axil_rst,
    input  logic [ADDR_WIDTH-1:0]       WADDR_FIFO_DOUT,
    input  logic                        WADDR_FIFO_EMPTY,
    output logic                        WADDR_FIFO_RD_EN,
    input  logic [DATA_WIDTH-1:0]       WDATA_FIFO_DOUT,
    input  logic                        WDATA_FIFO_EMPTY,
    output logic                        WDATA_FIFO_RD_EN,
    input  logic [ADDR_WIDTH-1:0]       RADDR_FIFO_DOUT,
    input  logic                        RADDR_FIFO_EMPTY,
    output logic                        RADDR_FIFO_RD_EN,
    input  logic                        RDATA_FIFO_FULL,
    output logic                        RDATA_FIFO_WR_EN,
    output logic [DATA_WIDTH-1:0]       RDATA_FIFO_DIN,
    output logic                        sdram_req,
    output logic                        sdram_we,
    output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0]       sdram_wdata,
    input  logic                        sdram_ack,
    input  logic                        sdram_rdata_valid,
    input  logic [DATA_WIDTH-1:0]       sdram_rdata,
    output logic                        busy,
    output logic                        err_timeout
);

    typedef enum logic [1:0] {IDLE, FETCH, REQ, RWAIT} state_t;
    typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

    state_t state, state_nxt;
    grant_t last_grant, last_grant_nxt;
    logic   wr_pend, rd_pend;
    logic   grant_wr, grant_rd;
    logic   rd_done, timeout_hit;

    assign wr_pend = !WADDR_FIFO_EMPTY && !WDATA_FIFO_EMPTY;
    assign rd_pend = !RADDR_FIFO_EMPTY && !RDATA_FIFO_FULL;

    // Grants drive the FIFO pops directly, so they are masked while reset is held.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE && !s_axil_rst) begin
            if (wr_pend && (last_grant == GRANT_RD || !rd_pend)) begin
                grant_wr = 1'b1;
            end else if (rd_pend) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign rd_done = (state == RWAIT) && (sdram_rdata_valid || timeout_hit);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt      = FETCH;
                    last_grant_nxt = GRANT_WR;
                end else if (grant_rd) begin
                    state_nxt      = FETCH;
                    last_grant_nxt = GRANT_RD;
                end
            end
            FETCH:   state_nxt = REQ;
            REQ:     if (sdram_ack) state_nxt = sdram_we ? IDLE : RWAIT;
            RWAIT:   if (rd_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
        if (s_axil_rst) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // FIFO heads are valid in FETCH, one cycle after the pop issued in IDLE.
    always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
        if (s_axil_rst) begin
            sdram_addr  <= '0;
            sdram_we    <= 1'b0;
            sdram_wdata <= '0;
        end else if (state == FETCH) begin
            sdram_we <= (last_grant == GRANT_WR);
            if (last_grant == GRANT_WR) begin
                sdram_addr  <= WADDR_FIFO_DOUT[SDRAM_ADDR_WIDTH+1:2];
                sdram_wdata <= WDATA_FIFO_DOUT;
            end else begin
                sdram_addr <= RADDR_FIFO_DOUT[SDRAM_ADDR_WIDTH+1:2];
            end
        end
    end

`ifdef AXIL_SDRAM_RD_TIMEOUT_EN
    localparam int              CNT_W           = $clog2(RD_TIMEOUT + 1);
    localparam logic [31:0]     TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    function automatic logic [DATA_WIDTH-1:0] timeout_fill();
        logic [DATA_WIDTH-1:0] w;
        for (int i = 0; i < DATA_WIDTH; i++) w[i] = TIMEOUT_PATTERN[i % 32];
        return w;
    endfunction

    localparam logic [DATA_WIDTH-1:0] TIMEOUT_WORD = timeout_fill();

    logic [CNT_W-1:0] rd_wait_cnt;

    always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
        if (s_axil_rst) begin
            rd_wait_cnt <= '0;
        end else if (state == RWAIT) begin
            rd_wait_cnt <= rd_wait_cnt + 1'b1;
        end else begin
            rd_wait_cnt <= '0;
        end
    end

    // Fires in the RD_TIMEOUT-th RWAIT cycle; real data in that same cycle still wins.
    assign timeout_hit    = (state == RWAIT) && !sdram_rdata_valid
                            && (rd_wait_cnt == CNT_W'(RD_TIMEOUT - 1));
    assign err_timeout    = timeout_hit;
    assign RDATA_FIFO_DIN = !RDATA_FIFO_WR_EN ? '0
                          : (sdram_rdata_valid ? sdram_rdata : TIMEOUT_WORD);
`else
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
    assign RDATA_FIFO_DIN = RDATA_FIFO_WR_EN ? sdram_rdata : '0;
`endif

    assign WADDR_FIFO_RD_EN = grant_wr;
    assign WDATA_FIFO_RD_EN = grant_wr;
    assign RADDR_FIFO_RD_EN = grant_rd;
    assign RDATA_FIFO_WR_EN = rd_done;
    assign sdram_req        = (state == REQ);
    // The grant cycle already commits the block, so busy covers it too.
    assign busy             = (state != IDLE) || grant_wr || grant_rd;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{WADDR_FIFO_DOUT[ADDR_WIDTH-1:SDRAM_ADDR_WIDTH+2], WADDR_FIFO_DOUT[1:0],
                                RADDR_FIFO_DOUT[ADDR_WIDTH-1:SDRAM_ADDR_WIDTH+2], RADDR_FIFO_DOUT[1:0]};

endmodule
